// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and uart timing constants
//
// Purpose: types and constants shared by the uart transmit arbiter files.
//   state_t         : arbiter FSM encoding (IDLE -> SEND -> WAIT -> IDLE)
//   UART_DIV        : uart baud divider in clock25 cycles per bit
//   UART_FRAME_BITS : start + 8 data + parity + stop
//   UART_FRAME_CYC  : one frame plus one bit of slack, lower bound for the watchdog
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int UART_DIV        = 54;
  localparam int UART_FRAME_BITS = 11;
  localparam int UART_FRAME_CYC  = UART_DIV * (UART_FRAME_BITS + 1);

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin arbiter
//
// Purpose: picks one of two requesters; on a tie the one that did not win last time.
// Ports:
//   valid      in  2  request vector, bit N = requester N
//   last_grant in  1  index of the previous winner
//   gnt        out 2  one-hot grant, zero when nothing is valid
//   gid        out 1  index of the winner (0 when nothing is valid)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gid
);

  always_comb begin
    gid = 1'b0;
    case (valid)
      2'b10:   gid = 1'b1;
      2'b11:   gid = ~last_grant;
      default: gid = 1'b0;
    endcase
    gnt = 2'b00;
    if (valid != 2'b00) begin
      gnt = gid ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one uart transmitter between two byte sources
//
// Purpose: round-robin arbitration of two valid/ready byte sources onto a single
// uart transmitter with an edge-triggered tx_send and an end-of-frame tx_ready pulse.
// A watchdog releases the requester if tx_ready never arrives.
// Ports:
//   clock25                 in   1  system clock
//   reset                   in   1  asynchronous active-high reset
//   req0_valid/req1_valid   in   1  requester has a byte
//   req0_byte/req1_byte     in   8  requester data
//   req0_ready/req1_ready   out  1  byte accepted this cycle (combinational)
//   req0_done/req1_done     out  1  one-cycle pulse: byte finished (or aborted)
//   tx_byte                 out  8  registered byte to the uart, held until next grant
//   tx_send                 out  1  registered send strobe, high SEND_HOLD cycles
//   tx_ready                in   1  uart end-of-frame pulse
//   busy                    out  1  high outside IDLE
//   timeout_err             out  1  one-cycle pulse on watchdog abort
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int SEND_HOLD = 2,
  parameter int TIMEOUT   = 1023,
  parameter int CW        = 10
) (
  input  logic       clock25,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  output logic       req0_ready,
  output logic       req0_done,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  output logic       req1_ready,
  output logic       req1_done,
  output logic [7:0] tx_byte,
  output logic       tx_send,
  input  logic       tx_ready,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(SEND_HOLD - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  // The counter never wraps as long as it can represent both terminal counts.
  if (SEND_HOLD < 1 || TIMEOUT < UART_FRAME_CYC ||
      (1 << CW) <= SEND_HOLD || (1 << CW) <= TIMEOUT) begin : g_param_check
    $error("uart_tx_arbiter: SEND_HOLD/TIMEOUT/CW out of range");
  end

  state_t        state;
  logic [CW-1:0] count;
  logic          last_grant;
  logic          gid_q;
  logic [1:0]    gnt;
  logic          win;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gid        (win)
  );

  // Ready is gated by reset so a requester holding valid through reset is not acked.
  assign req0_ready = (state == ST_IDLE) & gnt[0] & ~reset;
  assign req1_ready = (state == ST_IDLE) & gnt[1] & ~reset;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      last_grant  <= 1'b1;
      gid_q       <= 1'b0;
      tx_byte     <= 8'h00;
      tx_send     <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            tx_byte    <= win ? req1_byte : req0_byte;
            gid_q      <= win;
            last_grant <= win;
            tx_send    <= 1'b1;
            count      <= '0;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (count == HOLD_LAST) begin
            tx_send <= 1'b0;
            count   <= '0;
            state   <= ST_WAIT;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_WAIT: begin
          // A real tx_ready on the watchdog's last cycle counts as success.
          if (tx_ready || count == TIMEOUT_LAST) begin
            req0_done   <= ~gid_q;
            req1_done   <= gid_q;
            timeout_err <= ~tx_ready;
            count       <= '0;
            state       <= ST_IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          tx_send <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int SEND_HOLD = 2;
  localparam int TIMEOUT   = 1023;
  localparam int CW        = 10;

  logic       clock25 = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_byte, req1_byte;
  logic       req0_ready, req0_done, req1_ready, req1_done;
  logic [7:0] tx_byte;
  logic       tx_send, tx_ready, busy, timeout_err;

  always #20 clock25 = ~clock25;

  uart_tx_arbiter #(.SEND_HOLD(SEND_HOLD), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock25     (clock25),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_byte   (req0_byte),
    .req0_ready  (req0_ready),
    .req0_done   (req0_done),
    .req1_valid  (req1_valid),
    .req1_byte   (req1_byte),
    .req1_ready  (req1_ready),
    .req1_done   (req1_done),
    .tx_byte     (tx_byte),
    .tx_send     (tx_send),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_fails  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock25);
    #1;
  endtask

  // ---------------- uart transmitter model ----------------
  logic        uart_en     = 1'b0;
  logic        inj_ready   = 1'b0;
  logic        model_ready = 1'b0;
  logic        line        = 1'b1;
  logic        s1 = 1'b0, s2 = 1'b0;
  logic        active      = 1'b0;
  logic [10:0] frame       = '0;
  int          bit_idx     = 0;
  int          div_cnt     = 0;

  assign tx_ready = model_ready | inj_ready;

  always @(posedge clock25) begin
    model_ready <= 1'b0;
    s1 <= tx_send;
    s2 <= s1;
    if (reset) begin
      active <= 1'b0;
      line   <= 1'b1;
    end else if (!active) begin
      if (uart_en && s1 && !s2) begin
        frame   <= {1'b1, ^tx_byte, tx_byte, 1'b0};
        line    <= 1'b0;
        active  <= 1'b1;
        bit_idx <= 0;
        div_cnt <= 0;
      end
    end else if (div_cnt == UART_DIV - 1) begin
      div_cnt <= 0;
      if (bit_idx == UART_FRAME_BITS - 1) begin
        active      <= 1'b0;
        line        <= 1'b1;
        model_ready <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 1;
        line    <= frame[bit_idx + 1];
      end
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  // ---------------- serial line decoder ----------------
  logic [7:0] line_q[$];

  initial begin
    logic [7:0] d;
    forever begin
      @(negedge line);
      repeat (UART_DIV / 2) @(posedge clock25);
      #1;
      check("line_start", line, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (UART_DIV) @(posedge clock25);
        #1;
        d[i] = line;
      end
      repeat (UART_DIV) @(posedge clock25);
      #1;
      check("line_parity", line, ^d);
      repeat (UART_DIV) @(posedge clock25);
      #1;
      check("line_stop", line, 1);
      line_q.push_back(d);
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] src0_q[$], src1_q[$];
  logic [7:0] exp0_q[$], exp1_q[$], exp_line_q[$];
  logic       pend_q[$];
  logic       sb_en       = 1'b0;
  logic       sb_last     = 1'b1;
  int         sb_timeouts = 0;
  int         low_cnt     = 100;

  initial begin
    logic       w;
    logic [7:0] b;
    forever begin
      @(negedge clock25);
      if (reset) begin
        sb_last = 1'b1;
        low_cnt = 100;
      end else begin
        if (!tx_send) low_cnt++;
        else begin
          if (low_cnt != 0 && sb_en) check("send_low_gap", low_cnt >= 2, 1);
          low_cnt = 0;
        end
        if (req0_ready || req1_ready) begin
          w = req1_ready;
          if (sb_en) begin
            check("ready_onehot", req0_ready & req1_ready, 0);
            if (req0_valid && req1_valid) check("rr_alternate", w, !sb_last);
            b = w ? req1_byte : req0_byte;
            if (w) begin
              check("src1_has_byte", exp1_q.size() != 0, 1);
              if (exp1_q.size() != 0) check("src1_order", b, exp1_q.pop_front());
            end else begin
              check("src0_has_byte", exp0_q.size() != 0, 1);
              if (exp0_q.size() != 0) check("src0_order", b, exp0_q.pop_front());
            end
            exp_line_q.push_back(b);
            pend_q.push_back(w);
          end
          sb_last = w;
        end
        if (sb_en && (req0_done || req1_done)) begin
          check("done_onehot", req0_done & req1_done, 0);
          check("done_expected", pend_q.size() != 0, 1);
          if (pend_q.size() != 0) check("done_owner", req1_done, pend_q.pop_front());
        end
        if (timeout_err) sb_timeouts++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    inj_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic add(input bit id, input logic [7:0] b);
    if (id) begin
      src1_q.push_back(b);
      exp1_q.push_back(b);
    end else begin
      src0_q.push_back(b);
      exp0_q.push_back(b);
    end
  endtask

  task automatic drive(input bit id, input int gap_max);
    logic [7:0] b;
    logic       got;
    int         n;
    while ((id ? src1_q.size() : src0_q.size()) != 0) begin
      b = id ? src1_q.pop_front() : src0_q.pop_front();
      repeat ($urandom_range(gap_max, 0)) tick();
      if (id) begin req1_valid = 1'b1; req1_byte = b; end
      else    begin req0_valid = 1'b1; req0_byte = b; end
      got = 1'b0;
      n = 0;
      while (!got && n < 3000) begin
        @(negedge clock25);
        got = id ? req1_ready : req0_ready;
        tick();
        n++;
      end
      check($sformatf("req%0d_accepted", id), got, 1);
      if (!got) begin
        if (id) src1_q.delete(); else src0_q.delete();
      end
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
  endtask

  task automatic run_traffic(input int gap_max);
    int n;
    line_q.delete();
    exp_line_q.delete();
    pend_q.delete();
    sb_timeouts = 0;
    sb_en = 1'b1;
    fork
      drive(1'b0, gap_max);
      drive(1'b1, gap_max);
    join
    n = 0;
    while ((busy || pend_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check("traffic_drained", !busy && pend_q.size() == 0, 1);
    repeat (2) tick();
    check("line_count", line_q.size(), exp_line_q.size());
    for (int i = 0; i < line_q.size() && i < exp_line_q.size(); i++)
      check($sformatf("line_byte%0d", i), line_q[i], exp_line_q[i]);
    check("src_all_sent", exp0_q.size() + exp1_q.size(), 0);
    check("no_timeout", sb_timeouts, 0);
    sb_en = 1'b0;
  endtask

  typedef struct {
    logic       v0, v1;
    logic [7:0] b0, b1;
    logic       r0, r1;
    logic [7:0] bx;
  } vec_t;

  // One grant with the uart model silent; tx_ready is injected by hand.
  task automatic fast_xfer(input vec_t v, input string tag);
    int n;
    req0_valid = v.v0; req0_byte = v.b0;
    req1_valid = v.v1; req1_byte = v.b1;
    #1;
    check({tag, "_ready0"}, req0_ready, v.r0);
    check({tag, "_ready1"}, req1_ready, v.r1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (v.r0 || v.r1) begin
      check({tag, "_tx_byte"}, tx_byte, v.bx);
      check({tag, "_busy"}, busy, 1);
      n = 0;
      while (tx_send && n < 20) begin tick(); n++; end
      inj_ready = 1'b1;
      tick();
      inj_ready = 1'b0;
      check({tag, "_done0"}, req0_done, v.r0);
      check({tag, "_done1"}, req1_done, v.r1);
      check({tag, "_idle"}, busy, 0);
      tick();
    end else begin
      check({tag, "_no_grant_busy"}, busy, 0);
      check({tag, "_no_grant_send"}, tx_send, 0);
    end
  endtask

  task automatic wait_wait_entry();
    int n;
    n = 0;
    while (tx_send && n < 20) begin tick(); n++; end
  endtask

  initial begin
    #(40 * 150000);
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t       vecs[10];
    logic [7:0] cont_exp[4];
    int         n, cnt;
    logic       seen;

    vecs[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h11};
    vecs[1] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 8'h44};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 8'h55};
    vecs[3] = '{1'b1, 1'b1, 8'h66, 8'h77, 1'b1, 1'b0, 8'h66};
    vecs[4] = '{1'b1, 1'b0, 8'h88, 8'h00, 1'b1, 1'b0, 8'h88};
    vecs[5] = '{1'b1, 1'b1, 8'h99, 8'hAA, 1'b0, 1'b1, 8'hAA};
    vecs[6] = '{1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 8'hBB, 8'hCC, 1'b1, 1'b0, 8'hBB};
    vecs[8] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF};
    vecs[9] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 8'h02};
    cont_exp = '{8'h11, 8'h22, 8'h11, 8'h22};

    // Reset state
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_byte = 8'h00; req1_byte = 8'h00;
    repeat (3) tick();
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {req1_done, req0_done}, 0);
    check("rst_timeout", timeout_err, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_ready_gated", {req1_ready, req0_ready}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Arbitration table
    for (int i = 0; i < 10; i++) fast_xfer(vecs[i], $sformatf("vec%0d", i));

    // Single byte through the uart model
    uart_en = 1'b1;
    line_q.delete();
    req0_valid = 1'b1; req0_byte = 8'hA5;
    #1;
    check("single_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("single_ready_pulse", req0_ready, 0);
    n = 0;
    while (tx_send && n < 20) begin n++; tick(); end
    check("single_send_width", n, SEND_HOLD);
    n = 0; seen = 1'b0;
    while (!req0_done && n < 2 * UART_FRAME_CYC) begin seen = tx_ready; tick(); n++; end
    check("single_done", req0_done, 1);
    check("single_done_after_ready", seen, 1);
    check("single_idle", busy, 0);
    tick();
    check("single_done_pulse", req0_done, 0);
    check("single_line_count", line_q.size(), 1);
    if (line_q.size() != 0) check("single_line_byte", line_q[0], 8'hA5);
    uart_en = 1'b0;

    // Watchdog abort with tx_ready stuck low
    req0_valid = 1'b1; req0_byte = 8'h3C;
    tick();
    req0_valid = 1'b0;
    wait_wait_entry();
    n = 0;
    while (!timeout_err && n < TIMEOUT + 50) begin tick(); n++; end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_done0", req0_done, 1);
    check("timeout_idle", busy, 0);
    tick();
    check("timeout_pulse", timeout_err, 0);
    fast_xfer('{1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h5A}, "after_timeout");

    // tx_ready on the watchdog's last cycle wins
    req0_valid = 1'b1; req0_byte = 8'h77;
    tick();
    req0_valid = 1'b0;
    wait_wait_entry();
    repeat (TIMEOUT - 1) tick();
    inj_ready = 1'b1;
    tick();
    inj_ready = 1'b0;
    check("coinc_done", req0_done, 1);
    check("coinc_no_timeout", timeout_err, 0);
    tick();

    // tx_ready during SEND is ignored
    req1_valid = 1'b1; req1_byte = 8'h99;
    tick();
    req1_valid = 1'b0;
    inj_ready = 1'b1;
    tick();
    inj_ready = 1'b0;
    wait_wait_entry();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (req1_done || req0_done) cnt++;
      tick();
    end
    check("send_ready_ignored", cnt, 0);
    check("send_ready_still_busy", busy, 1);
    inj_ready = 1'b1;
    tick();
    inj_ready = 1'b0;
    check("send_ready_real_done", req1_done, 1);
    tick();

    // Reset during SEND
    req0_valid = 1'b1; req0_byte = 8'h42;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_byte = 8'h24;
    check("midrst_in_send", tx_send, 1);
    reset = 1'b1;
    #1;
    check("midrst_tx_send", tx_send, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", {req1_ready, req0_ready}, 0);
    check("midrst_done", {req1_done, req0_done}, 0);
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_byte = 8'h43;
    #1;
    check("midrst_tie_ready0", req0_ready, 1);
    check("midrst_tie_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_wait_entry();
    inj_ready = 1'b1;
    tick();
    inj_ready = 1'b0;
    tick();

    // Contention from reset
    uart_en = 1'b1;
    do_reset();
    add(1'b0, 8'h11); add(1'b1, 8'h22); add(1'b0, 8'h11); add(1'b1, 8'h22);
    run_traffic(0);
    for (int i = 0; i < 4; i++)
      if (i < line_q.size()) check($sformatf("contention_order%0d", i), line_q[i], cont_exp[i]);

    // Back-to-back stream from requester 1
    for (int i = 0; i < 16; i++) add(1'b1, 8'(i));
    run_traffic(0);
    for (int i = 0; i < 16; i++)
      if (i < line_q.size()) check($sformatf("stream_byte%0d", i), line_q[i], 8'(i));

    // Randomised traffic
    for (int s = 0; s < 2; s++) begin
      n = int'($urandom_range(5, 2));
      for (int i = 0; i < n; i++) add(s[0], 8'($urandom));
    end
    run_traffic(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart transmitter between two byte sources (for example a debug/console path and a data-dump path).
- Per-requester valid/ready handshake, round-robin grant.
- Drives the transmitter's edge-triggered tx_send and holds tx_byte stable for the sample window.
- Waits for the transmitter's tx_ready pulse; a watchdog recovers if that pulse never arrives.

Parameters:
- SEND_HOLD, 2: cycles tx_send is held high per byte (min 1; the uart samples tx_byte one cycle after the rising edge).
- TIMEOUT, 1023: cycles in WAIT without tx_ready before abort. Must exceed one 11-bit frame at divider 54 (>=648).
- CW, 10: width of the hold/watchdog counter; must hold max(SEND_HOLD, TIMEOUT).

Ports:
- clock25  in  1  system clock, 25 MHz
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_byte  in  8  requester 0 data
- req0_ready  out  1  one-cycle pulse: req0_byte accepted this cycle
- req0_done  out  1  one-cycle pulse: requester 0 byte fully transmitted
- req1_valid  in  1  requester 1 has a byte
- req1_byte  in  8  requester 1 data
- req1_ready  out  1  one-cycle pulse: req1_byte accepted
- req1_done  out  1  one-cycle pulse: requester 1 byte transmitted
- tx_byte  out  8  to uart tx_byte, registered
- tx_send  out  1  to uart tx_send, registered
- tx_ready  in  1  from uart: one-cycle end-of-frame pulse
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async): state=IDLE, tx_send=0, tx_byte=0, all ready/done/timeout_err=0, last_grant=1 (so requester 0 wins the first tie), counter=0.
- Reset mid-frame: tx_send drops immediately. The uart is not reset by this block, so the system must not assert reset mid-frame except at power-up.
- States: IDLE -> SEND -> WAIT -> IDLE.
- IDLE:
  - If any valid, pick a winner. Single valid wins. Both valid: the one != last_grant wins.
  - On that clock edge: tx_byte<=winner byte, reqN_ready=1 for that cycle (combinational from the arbiter and IDLE), gid<=winner, last_grant<=winner, tx_send<=1, counter<=0, go to SEND.
  - Requester drops or changes its byte only after seeing ready.
- SEND:
  - tx_send stays 1, counter increments.
  - When counter==SEND_HOLD-1: tx_send<=0, counter<=0, go to WAIT.
  - tx_ready seen in SEND is ignored.
- WAIT:
  - tx_send=0, counter increments.
  - On tx_ready: reqN_done pulse for N=gid next cycle (registered), go to IDLE.
  - Else if counter==TIMEOUT-1: timeout_err pulse and reqN_done pulse (so the requester is not left hanging), go to IDLE.
  - tx_ready and timeout in the same cycle: tx_ready wins, no timeout_err.
- tx_byte is held unchanged from grant until the next grant.
- Earliest next grant is the cycle after leaving WAIT. tx_send is therefore low for >=2 cycles between bytes, guaranteeing a clean rising edge for the uart's 2-stage edge detector.
- tx_ready seen in IDLE is ignored.
- Throughput: one byte per frame + SEND_HOLD + 2 cycles.
- Counter wraps are impossible by the CW rule; the implementation checks CW via a parameter assertion.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (ST_IDLE, ST_SEND, ST_WAIT, 2 bits)
  - UART_DIV=54
  - UART_FRAME_BITS=11
  - derived UART_FRAME_CYC=UART_DIV*(UART_FRAME_BITS+1)
- One natural sub-module: rr_arb2. Combinational 2-way round-robin taking valid[1:0] and last_grant, returning gnt[1:0] one-hot and gid.
- FSM, counter and tx registers stay in uart_tx_arbiter.

Test Plan:
- Single byte: req0 0xA5, uart model at divider 54 -> req0_ready pulse at grant; tx_send high 2 cycles; line shows start, 10100101 LSB-first, even-parity 0, stop; req0_done 1 cycle after tx_ready; busy low after.
- Contention: req0 0x11 and req1 0x22 valid same cycle from reset -> order 0x11, 0x22, 0x11, 0x22 when both keep requesting; no byte lost or duplicated.
- Back-to-back: req1 streams 0x00..0x0F -> 16 frames; tx_send low >=2 cycles between pulses; each byte sampled correctly by the uart model.
- Timeout: uart model with tx_ready stuck 0 -> timeout_err pulse exactly TIMEOUT cycles after WAIT entry; req0_done pulses; next request is served.
- Coincidence: tx_ready forced in the cycle counter==TIMEOUT-1 -> done pulse, no timeout_err. tx_ready injected during SEND -> ignored, FSM still waits for a real tx_ready.
- Reset mid-SEND: assert reset while tx_send=1 -> tx_send, ready, done, busy all 0 asynchronously; after release the first tie goes to req0.
